// File: rtl/cpu_dmem_responder_if.sv
// CPU data-bus interface: one-cycle request strobe plus in-order ack/error/rdata return.
interface cpu_dmem_responder_if;
  logic        cpud_request;
  logic [31:0] cpud_addr;
  logic        cpud_write;
  logic [3:0]  cpud_byte_enable;
  logic [31:0] cpud_wdata;
  logic [31:0] cpud_rdata;
  logic        cpud_ack;
  logic        cpud_error;

  modport master (
    output cpud_request,
    output cpud_addr,
    output cpud_write,
    output cpud_byte_enable,
    output cpud_wdata,
    input  cpud_rdata,
    input  cpud_ack,
    input  cpud_error
  );

  modport slave (
    input  cpud_request,
    input  cpud_addr,
    input  cpud_write,
    input  cpud_byte_enable,
    input  cpud_wdata,
    output cpud_rdata,
    output cpud_ack,
    output cpud_error
  );
endinterface

// File: rtl/cpu_dmem_responder.sv
// Target end of the CPU data bus: request FIFO, fixed-latency service FSM and a
// byte-enable word RAM. Exactly one ack per accepted request, strictly in order.
module cpu_dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  cpu_dmem_responder_if.slave  cpud,
  output logic                 overflow
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned Words = 2 ** ADDR_WIDTH;
  localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);
  localparam logic [2:0]      CntLoad  = 3'(LATENCY - 1);

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_t;

  // Request FIFO
  req_t            r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  req_t            w_head;
  req_t            w_req_in;

  // Service FSM
  state_t          r_state;
  state_t          w_state_next;
  logic [2:0]      r_cnt;
  logic [2:0]      w_cnt_next;
  logic            w_enter_ack;
  req_t            r_cur;
  req_t            w_op;

  // Address decode
  logic [32:0]     w_offset;
  logic [29:0]     w_word;
  logic            w_in_range;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic            w_unused_offset;

  // Outputs and storage
  logic            r_ack;
  logic            r_error;
  logic [31:0]     r_rdata;
  logic            r_overflow;
  logic [31:0]     r_mem [Words];

  assign w_req_in = '{addr:  cpud.cpud_addr,
                      write: cpud.cpud_write,
                      be:    cpud.cpud_byte_enable,
                      wdata: cpud.cpud_wdata};

  assign w_full  = (r_count == FifoFull);
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rptr];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = cpud.cpud_request && (!w_full || w_pop);
  assign w_drop  = cpud.cpud_request && w_full && !w_pop;

  // Next-state: pop from IDLE or ACK, count down wait states in BUSY.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pop        = 1'b0;
    unique case (r_state)
      StIdle, StAck: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_cnt_next   = CntLoad;
          w_state_next = (LATENCY == 1) ? StAck : StBusy;
        end else begin
          w_state_next = StIdle;
        end
      end
      StBusy: begin
        if (r_cnt == 3'd1) begin
          w_state_next = StAck;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // The access is performed at the edge entering ACK. With LATENCY==1 that is the
  // same edge that pops, so the request comes straight from the FIFO head.
  assign w_enter_ack = (w_state_next == StAck);
  assign w_op        = (r_state == StBusy) ? r_cur : w_head;

  // Borrow out of the 33-bit subtraction means the address is below BASE_ADDR.
  assign w_offset        = {1'b0, w_op.addr} - {1'b0, BASE_ADDR};
  assign w_word          = w_offset[31:2];
  assign w_in_range      = !w_offset[32] && ((w_word >> ADDR_WIDTH) == 30'd0);
  assign w_idx           = w_word[ADDR_WIDTH-1:0];
  assign w_unused_offset = ^w_offset[1:0];

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wptr] <= w_req_in;
  end

  // FSM state, wait counter and the request being serviced.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_cur   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_pop) r_cur <= w_head;
    end
  end

  // Ack/error strobes and read data; rdata only changes on a read ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ack   <= 1'b0;
      r_error <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_enter_ack;
      r_error <= w_enter_ack && !w_in_range;
      if (w_enter_ack && !w_op.write) begin
        r_rdata <= w_in_range ? r_mem[w_idx] : 32'h0;
      end
    end
  end

  // RAM write of enabled lanes; not reset.
  always_ff @(posedge clock) begin
    if (w_enter_ack && w_op.write && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (w_op.be[b]) r_mem[w_idx][8*b +: 8] <= w_op.wdata[8*b +: 8];
      end
    end
  end

  assign cpud.cpud_ack   = r_ack;
  assign cpud.cpud_error = r_error;
  assign cpud.cpud_rdata = r_rdata;
  assign overflow        = r_overflow;

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Scoreboard bench for cpu_dmem_responder: three instances (LATENCY 2/3/4) share
// one stimulus bus gated by a select; per-instance monitors pop expected acks.
module tb_cpu_dmem_responder;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   = 1'b0;
  int          sel   = 0;
  logic        wr    = 1'b0;
  logic [3:0]  be    = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ovf2, ovf3, ovf4;
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t q4[$];

  cpu_dmem_responder_if i2 ();
  cpu_dmem_responder_if i3 ();
  cpu_dmem_responder_if i4 ();

  assign i2.cpud_request = req && (sel == 2);
  assign i3.cpud_request = req && (sel == 3);
  assign i4.cpud_request = req && (sel == 4);
  assign {i2.cpud_addr, i2.cpud_write, i2.cpud_byte_enable, i2.cpud_wdata} = {addr, wr, be, wdata};
  assign {i3.cpud_addr, i3.cpud_write, i3.cpud_byte_enable, i3.cpud_wdata} = {addr, wr, be, wdata};
  assign {i4.cpud_addr, i4.cpud_write, i4.cpud_byte_enable, i4.cpud_wdata} = {addr, wr, be, wdata};

  cpu_dmem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .LATENCY(2), .FIFO_DEPTH(2)) u2 (
    .clock(clk), .reset_n(rst_n), .cpud(i2), .overflow(ovf2));
  cpu_dmem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .LATENCY(3), .FIFO_DEPTH(2)) u3 (
    .clock(clk), .reset_n(rst_n), .cpud(i3), .overflow(ovf3));
  cpu_dmem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .LATENCY(4), .FIFO_DEPTH(2)) u4 (
    .clock(clk), .reset_n(rst_n), .cpud(i4), .overflow(ovf4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_ack(input string nm, input exp_t e, input logic [31:0] rd, input logic err);
    chk({nm, " ack cycle"}, 32'(cyc), 32'(e.cyc));
    chk({nm, " rdata"}, rd, e.rd);
    chk({nm, " error"}, {31'b0, err}, {31'b0, e.err});
  endtask

  // Monitors: every ack must match the oldest expectation; error only with ack.
  always @(negedge clk) begin : mon2
    exp_t e;
    if (i2.cpud_ack === 1'b1) begin
      if (q2.size() == 0) chk("u2 unexpected ack", {31'b0, i2.cpud_ack}, 32'h0);
      else begin e = q2.pop_front(); chk_ack("u2", e, i2.cpud_rdata, i2.cpud_error); end
    end else chk("u2 error without ack", {31'b0, i2.cpud_error}, 32'h0);
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (i3.cpud_ack === 1'b1) begin
      if (q3.size() == 0) chk("u3 unexpected ack", {31'b0, i3.cpud_ack}, 32'h0);
      else begin e = q3.pop_front(); chk_ack("u3", e, i3.cpud_rdata, i3.cpud_error); end
    end else chk("u3 error without ack", {31'b0, i3.cpud_error}, 32'h0);
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (i4.cpud_ack === 1'b1) begin
      if (q4.size() == 0) chk("u4 unexpected ack", {31'b0, i4.cpud_ack}, 32'h0);
      else begin e = q4.pop_front(); chk_ack("u4", e, i4.cpud_rdata, i4.cpud_error); end
    end else chk("u4 error without ack", {31'b0, i4.cpud_error}, 32'h0);
  end

  // Drive one request pulse from a negedge; off>0 queues an ack expected off cycles
  // after the sampling edge, off==0 means no ack may ever appear for it.
  task automatic send(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic [31:0] rd, input logic er,
                      input int off);
    exp_t e;
    sel = k; wr = w; addr = a; be = b; wdata = d; req = 1'b1;
    if (off > 0) begin
      e.cyc = cyc + 1 + off; e.rd = rd; e.err = er;
      case (k)
        2:       q2.push_back(e);
        3:       q3.push_back(e);
        default: q4.push_back(e);
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset u2 ack", {31'b0, i2.cpud_ack}, 32'h0);
    chk("reset u2 rdata", i2.cpud_rdata, 32'h0);
    chk("reset u2 overflow", {31'b0, ovf2}, 32'h0);
    chk("reset u4 rdata", i4.cpud_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: write then read, LATENCY=2
    send(2, 1'b1, 32'h10, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 2); idle(4);
    send(2, 1'b0, 32'h10, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 2); idle(4);

    // T2: partial-lane write, be=0 write, then read-after-write back-to-back
    send(2, 1'b1, 32'h20, 4'hF, 32'hAABB_CCDD, 32'h1234_5678, 1'b0, 2); idle(4);
    send(2, 1'b1, 32'h20, 4'b0010, 32'h0000_EE00, 32'h1234_5678, 1'b0, 2); idle(4);
    send(2, 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 2); idle(4);
    send(2, 1'b0, 32'h20, 4'h0, 32'h0, 32'hAABB_EEDD, 1'b0, 2); idle(4);
    send(2, 1'b1, 32'h30, 4'hF, 32'hCAFE_F00D, 32'hAABB_EEDD, 1'b0, 2);
    send(2, 1'b0, 32'h30, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 3); idle(6);

    // T5: out-of-range accesses (0x0010_0000 and 0x4000 alias word 0 if unchecked)
    send(2, 1'b1, 32'h0, 4'hF, 32'h1111_1111, 32'hCAFE_F00D, 1'b0, 2); idle(4);
    send(2, 1'b0, 32'h0010_0000, 4'h0, 32'h0, 32'h0, 1'b1, 2); idle(4);
    send(2, 1'b1, 32'h0010_0000, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1, 2); idle(4);
    send(2, 1'b0, 32'h0, 4'h0, 32'h0, 32'h1111_1111, 1'b0, 2); idle(4);
    send(2, 1'b0, 32'h4000, 4'h0, 32'h0, 32'h0, 1'b1, 2); idle(4);
    send(2, 1'b1, 32'h3FFC, 4'hF, 32'h5A5A_5A5A, 32'h0, 1'b0, 2); idle(4);
    send(2, 1'b0, 32'h3FFC, 4'h0, 32'h0, 32'h5A5A_5A5A, 1'b0, 2); idle(4);
    chk("u2 overflow stays 0", {31'b0, ovf2}, 32'h0);

    // T3: LATENCY=3, three back-to-back reads fill the 2-deep FIFO exactly
    send(3, 1'b1, 32'h0, 4'hF, 32'h1000_0001, 32'h0, 1'b0, 3); idle(5);
    send(3, 1'b1, 32'h4, 4'hF, 32'h2000_0002, 32'h0, 1'b0, 3); idle(5);
    send(3, 1'b1, 32'h8, 4'hF, 32'h3000_0003, 32'h0, 1'b0, 3); idle(5);
    send(3, 1'b0, 32'h0, 4'h0, 32'h0, 32'h1000_0001, 1'b0, 3);
    send(3, 1'b0, 32'h4, 4'h0, 32'h0, 32'h2000_0002, 1'b0, 5);
    send(3, 1'b0, 32'h8, 4'h0, 32'h0, 32'h3000_0003, 1'b0, 7); idle(12);
    chk("u3 overflow stays 0", {31'b0, ovf3}, 32'h0);

    // T4: LATENCY=4, four back-to-back writes; the 4th is dropped
    send(4, 1'b1, 32'h4C, 4'hF, 32'h0BAD_0BAD, 32'h0, 1'b0, 4); idle(6);
    send(4, 1'b1, 32'h40, 4'hF, 32'hA1A1_A1A1, 32'h0, 1'b0, 4);
    send(4, 1'b1, 32'h44, 4'hF, 32'hB2B2_B2B2, 32'h0, 1'b0, 7);
    send(4, 1'b1, 32'h48, 4'hF, 32'hC3C3_C3C3, 32'h0, 1'b0, 10);
    send(4, 1'b1, 32'h4C, 4'hF, 32'hD4D4_D4D4, 32'h0, 1'b0, 0);
    idle(1);
    chk("u4 overflow set", {31'b0, ovf4}, 32'h1);
    idle(14);
    chk("u4 overflow sticky", {31'b0, ovf4}, 32'h1);
    send(4, 1'b0, 32'h40, 4'h0, 32'h0, 32'hA1A1_A1A1, 1'b0, 4); idle(6);
    send(4, 1'b0, 32'h44, 4'h0, 32'h0, 32'hB2B2_B2B2, 1'b0, 4); idle(6);
    send(4, 1'b0, 32'h48, 4'h0, 32'h0, 32'hC3C3_C3C3, 1'b0, 4); idle(6);
    send(4, 1'b0, 32'h4C, 4'h0, 32'h0, 32'h0BAD_0BAD, 1'b0, 4); idle(6);

    // T6: reset mid-BUSY with one request queued; neither may ever ack
    send(4, 1'b0, 32'h40, 4'h0, 32'h0, 32'h0, 1'b0, 0);
    send(4, 1'b0, 32'h44, 4'h0, 32'h0, 32'h0, 1'b0, 0);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("T6 u4 ack in reset", {31'b0, i4.cpud_ack}, 32'h0);
    chk("T6 u4 error in reset", {31'b0, i4.cpud_error}, 32'h0);
    chk("T6 u4 rdata in reset", i4.cpud_rdata, 32'h0);
    chk("T6 u4 overflow in reset", {31'b0, ovf4}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(15);
    send(4, 1'b0, 32'h40, 4'h0, 32'h0, 32'hA1A1_A1A1, 1'b0, 4); idle(6);
    send(2, 1'b0, 32'h10, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 2); idle(6);

    chk("u2 acks outstanding", 32'(q2.size()), 32'h0);
    chk("u3 acks outstanding", 32'(q3.size()), 32'h0);
    chk("u4 acks outstanding", 32'(q4.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
